// File: rtl/eth_tx_pkg.sv
// Shared definitions for the Ethernet II + IPv4 transmit framer.
// Contents: FSM state enum, header constants, latched-metadata struct and
// the ones-complement add used by the IPv4 header checksum.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CSUM,
        HDR,
        PAYLOAD,
        FCS,
        DRAIN
    } eth_tx_state_e;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam int          ETH_HDR_BYTES  = 14;
    localparam int          IPV4_HDR_BYTES = 20;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [7:0]  protocol;
        logic [15:0] payload_len;
    } eth_tx_meta_s;

    // 16-bit add with the end-around carry folded back in. A single fold is
    // enough: 0xFFFF + 0xFFFF = 0x1FFFE folds to 0xFFFF without a new carry.
    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// Byte-wise Ethernet CRC-32 step (reflected polynomial 0xEDB88320).
// Ports: crc_i - running CRC, data_i - next byte, crc_o - updated CRC.
// Purely combinational; init and final inversion are handled by the caller.
module crc32_byte (
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);
    always_comb begin
        logic [31:0] c;
        c = crc_i ^ {24'd0, data_i};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        crc_o = c;
    end
endmodule

// File: rtl/eth_ipv4_tx_framer.sv
// Ethernet II + IPv4 transmit framer. Accepts one metadata beat, computes
// the IPv4 header checksum, emits the 34-byte header, then passes the L4
// segment through byte by byte.
// Ports: clk/rst (async active-high), meta_* (header metadata handshake),
//        s_axis_* (L4 bytes in), m_axis_* (framed bytes out),
//        err_pulse_o (length mismatch / oversize), busy_o (not IDLE).
// Build option: define ETH_FCS_EN to pad to 60 bytes and append CRC-32 FCS.
module eth_ipv4_tx_framer
    import eth_tx_pkg::*;
#(
    parameter logic [7:0] TTL           = 8'd64,
    parameter int          MAX_PAYLOAD   = 1480,
    parameter bit          DONT_FRAGMENT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        meta_valid_i,
    output logic        meta_ready_o,
    input  logic [47:0] meta_dst_mac_i,
    input  logic [47:0] meta_src_mac_i,
    input  logic [31:0] meta_src_ip_i,
    input  logic [31:0] meta_dst_ip_i,
    input  logic [7:0]  meta_protocol_i,
    input  logic [15:0] meta_payload_len_i,
    input  logic [7:0]  s_axis_tdata_i,
    input  logic        s_axis_tvalid_i,
    output logic        s_axis_tready_o,
    input  logic        s_axis_tlast_i,
    output logic [7:0]  m_axis_tdata_o,
    output logic        m_axis_tvalid_o,
    input  logic        m_axis_tready_i,
    output logic        m_axis_tlast_o,
    output logic        err_pulse_o,
    output logic        busy_o
);
    eth_tx_state_e state_q;
    eth_tx_meta_s  meta_q;
    logic [15:0]   ident_q, frame_ident_q, sum_q, cnt_q;
    logic [5:0]    idx_q;
    logic          err_q;

    logic [15:0]  total_len, flags, csum_word;
    logic [271:0] hdr_vec;
    logic [8:0]   hdr_bit;
    logic         m_hs, s_hs, last_pay;

    assign total_len = 16'(IPV4_HDR_BYTES) + meta_q.payload_len;
    assign flags     = DONT_FRAGMENT ? 16'h4000 : 16'h0000;
    assign hdr_vec   = {meta_q.dst_mac, meta_q.src_mac, ETHERTYPE_IPV4, IPV4_VER_IHL, 8'h00,
                        total_len, frame_ident_q, flags, TTL, meta_q.protocol, ~sum_q,
                        meta_q.src_ip, meta_q.dst_ip};
    assign hdr_bit   = 9'd264 - {idx_q, 3'b000};
    assign m_hs      = m_axis_tvalid_o & m_axis_tready_i;
    assign s_hs      = s_axis_tvalid_i & s_axis_tready_o;
    assign last_pay  = (cnt_q + 16'd1) == meta_q.payload_len;

    assign meta_ready_o = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign err_pulse_o  = err_q;

`ifdef ETH_FCS_EN
    localparam logic [15:0] PAD_END = 16'(60 - ETH_HDR_BYTES - IPV4_HDR_BYTES);
    logic [31:0] crc_q, crc_next;
    logic        pad;
    assign pad = cnt_q < PAD_END;
    crc32_byte u_crc (.crc_i(crc_q), .data_i(m_axis_tdata_o), .crc_o(crc_next));
`endif

    always_comb begin
        case (idx_q)
            6'd0:    csum_word = {IPV4_VER_IHL, 8'h00};
            6'd1:    csum_word = total_len;
            6'd2:    csum_word = frame_ident_q;
            6'd3:    csum_word = flags;
            6'd4:    csum_word = {TTL, meta_q.protocol};
            6'd5:    csum_word = meta_q.src_ip[31:16];
            6'd6:    csum_word = meta_q.src_ip[15:0];
            6'd7:    csum_word = meta_q.dst_ip[31:16];
            default: csum_word = meta_q.dst_ip[15:0];
        endcase
    end

    always_comb begin
        m_axis_tdata_o  = hdr_vec[hdr_bit +: 8];
        m_axis_tvalid_o = 1'b0;
        m_axis_tlast_o  = 1'b0;
        s_axis_tready_o = 1'b0;
        case (state_q)
            HDR: begin
                m_axis_tvalid_o = 1'b1;
`ifndef ETH_FCS_EN
                m_axis_tlast_o  = (idx_q == 6'd33) && (meta_q.payload_len == 16'd0);
`endif
            end
            PAYLOAD: begin
                m_axis_tdata_o  = s_axis_tdata_i;
                m_axis_tvalid_o = s_axis_tvalid_i;
                s_axis_tready_o = m_axis_tready_i;
`ifdef ETH_FCS_EN
                // A clean end hands tlast over to the FCS; only error ends carry it here.
                m_axis_tlast_o  = s_axis_tlast_i ^ last_pay;
`else
                m_axis_tlast_o  = s_axis_tlast_i | last_pay;
`endif
            end
`ifdef ETH_FCS_EN
            FCS: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = pad ? 8'h00 : ~crc_q[{idx_q[1:0], 3'b000} +: 8];
                m_axis_tlast_o  = !pad && (idx_q == 6'd3);
            end
`endif
            DRAIN:   s_axis_tready_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            meta_q        <= '0;
            ident_q       <= 16'h0000;
            frame_ident_q <= 16'h0000;
            sum_q         <= 16'h0000;
            cnt_q         <= 16'h0000;
            idx_q         <= 6'd0;
            err_q         <= 1'b0;
`ifdef ETH_FCS_EN
            crc_q         <= 32'hFFFFFFFF;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: if (meta_valid_i) begin
                    meta_q        <= '{dst_mac: meta_dst_mac_i, src_mac: meta_src_mac_i,
                                       src_ip: meta_src_ip_i, dst_ip: meta_dst_ip_i,
                                       protocol: meta_protocol_i, payload_len: meta_payload_len_i};
                    frame_ident_q <= ident_q;
                    ident_q       <= ident_q + 16'd1;
                    sum_q         <= 16'h0000;
                    cnt_q         <= 16'h0000;
                    idx_q         <= 6'd0;
`ifdef ETH_FCS_EN
                    crc_q         <= 32'hFFFFFFFF;
`endif
                    if (int'(meta_payload_len_i) > MAX_PAYLOAD) begin
                        err_q   <= 1'b1;
                        state_q <= DRAIN;
                    end else begin
                        state_q <= CSUM;
                    end
                end
                CSUM: begin
                    sum_q <= csum_add(sum_q, csum_word);
                    if (idx_q == 6'd8) begin
                        idx_q   <= 6'd0;
                        state_q <= HDR;
                    end else begin
                        idx_q <= idx_q + 6'd1;
                    end
                end
                HDR: if (m_hs) begin
`ifdef ETH_FCS_EN
                    crc_q <= crc_next;
`endif
                    if (idx_q == 6'd33) begin
                        idx_q <= 6'd0;
                        if (meta_q.payload_len != 16'd0) state_q <= PAYLOAD;
`ifdef ETH_FCS_EN
                        else state_q <= FCS;
`else
                        else state_q <= IDLE;
`endif
                    end else begin
                        idx_q <= idx_q + 6'd1;
                    end
                end
                PAYLOAD: if (s_hs) begin
`ifdef ETH_FCS_EN
                    crc_q <= crc_next;
`endif
                    cnt_q <= cnt_q + 16'd1;
                    if (s_axis_tlast_i) begin
                        err_q <= !last_pay;
`ifdef ETH_FCS_EN
                        state_q <= last_pay ? FCS : IDLE;
`else
                        state_q <= IDLE;
`endif
                    end else if (last_pay) begin
                        err_q   <= 1'b1;
                        state_q <= DRAIN;
                    end
                end
`ifdef ETH_FCS_EN
                FCS: if (m_hs) begin
                    if (pad) begin
                        cnt_q <= cnt_q + 16'd1;
                        crc_q <= crc_next;
                    end else if (idx_q == 6'd3) begin
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q + 6'd1;
                    end
                end
`endif
                DRAIN: if (s_axis_tvalid_i && s_axis_tlast_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_ipv4_tx_framer.sv
// Directed bench for eth_ipv4_tx_framer (default build, no FCS).
module tb_eth_ipv4_tx_framer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        meta_valid = 1'b0, meta_ready;
    logic [47:0] meta_dst_mac = '0, meta_src_mac = '0;
    logic [31:0] meta_src_ip = '0, meta_dst_ip = '0;
    logic [7:0]  meta_protocol = '0;
    logic [15:0] meta_payload_len = '0;
    logic [7:0]  s_tdata = '0, m_tdata;
    logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    logic        m_tvalid, m_tready = 1'b1, m_tlast;
    logic        err_pulse, busy;

    localparam logic [47:0] DMAC = 48'h02_11_22_33_44_55;
    localparam logic [47:0] SMAC = 48'h02_AA_BB_CC_DD_EE;
    localparam logic [31:0] SIP  = 32'hC0A80001;
    localparam logic [31:0] DIP  = 32'hC0A800C7;
    localparam logic [7:0]  PROTO = 8'h11;

    int n_checks = 0, n_errors = 0;
    logic [7:0] pay [0:2047];
    logic [7:0] out_q[$], exp_q[$];
    int tlast_pos, n_tlast, n_err, first_valid, s_taken;

    eth_ipv4_tx_framer dut (
        .clk(clk), .rst(rst),
        .meta_valid_i(meta_valid), .meta_ready_o(meta_ready),
        .meta_dst_mac_i(meta_dst_mac), .meta_src_mac_i(meta_src_mac),
        .meta_src_ip_i(meta_src_ip), .meta_dst_ip_i(meta_dst_ip),
        .meta_protocol_i(meta_protocol), .meta_payload_len_i(meta_payload_len),
        .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid),
        .s_axis_tready_o(s_tready), .s_axis_tlast_i(s_tlast),
        .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid),
        .m_axis_tready_i(m_tready), .m_axis_tlast_o(m_tlast),
        .err_pulse_o(err_pulse), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 2048; i++) pay[i] = 8'(i * 13 + 5);
    endtask

    task automatic send_meta(input logic [15:0] len);
        @(negedge clk);
        meta_dst_mac = DMAC; meta_src_mac = SMAC; meta_src_ip = SIP; meta_dst_ip = DIP;
        meta_protocol = PROTO; meta_payload_len = len; meta_valid = 1'b1;
        #1 chk("meta_ready_idle", meta_ready, 1'b1);
        @(posedge clk);
        #1 meta_valid = 1'b0;
    endtask

    // Runs one frame after the metadata handshake, offering n_in payload bytes
    // (tlast on index tlast_at) and collecting every accepted output byte.
    task automatic run(input int n_in, input int tlast_at, input bit stall, input int budget);
        int k = 0, cyc = 0;
        logic prev_v = 1'b0, prev_r = 1'b1;
        logic [7:0] prev_d = 8'h00;
        out_q.delete();
        tlast_pos = -1; n_tlast = 0; n_err = 0; first_valid = -1;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            s_tvalid = (k < n_in);
            s_tdata  = (k < n_in) ? pay[k] : 8'h00;
            s_tlast  = (k == tlast_at);
            #1;
            if (prev_v && !prev_r) begin
                chk("stall_hold_valid", m_tvalid, 1'b1);
                chk("stall_hold_data", m_tdata, prev_d);
            end
            if (err_pulse) n_err++;
            if (m_tvalid && first_valid < 0) first_valid = cyc;
            if (m_tvalid && m_tready) begin
                out_q.push_back(m_tdata);
                if (m_tlast) begin
                    n_tlast++;
                    tlast_pos = out_q.size() - 1;
                end
            end
            if (s_tvalid && s_tready) k++;
            prev_v = m_tvalid; prev_r = m_tready; prev_d = m_tdata;
            if (!busy) break;
        end
        if (busy) chk("frame_timeout_busy", busy, 1'b0);
        s_taken  = k;
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    endtask

    task automatic build(input int len, input logic [15:0] id, input logic [15:0] cs, input int npay);
        logic [271:0] h;
        h = {DMAC, SMAC, 16'h0800, 8'h45, 8'h00, 16'(20 + len), id, 16'h4000, 8'd64,
             PROTO, cs, SIP, DIP};
        exp_q.delete();
        for (int i = 0; i < 34; i++) exp_q.push_back(h[271 - 8 * i -: 8]);
        for (int i = 0; i < npay; i++) exp_q.push_back(pay[i]);
    endtask

    task automatic cmp_frame(input string tag, input bit skip_id);
        int mism = 0;
        chk({tag, "_size"}, out_q.size(), exp_q.size());
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            if (skip_id && (i == 18 || i == 19 || i == 24 || i == 25)) continue;
            if (out_q[i] !== exp_q[i]) mism++;
        end
        chk({tag, "_byte_mismatches"}, mism, 0);
    endtask

    initial begin
        logic [7:0] ip_exp [20];
        int hs, cyc;
        ip_exp = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                   8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
        fill_pattern();

        // Reset values while held in reset, then release.
        repeat (2) @(negedge clk);
        chk("rst_meta_ready", meta_ready, 1'b1);
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_m_tlast", m_tlast, 1'b0);
        chk("rst_s_tready", s_tready, 1'b0);
        chk("rst_err", err_pulse, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // Frame 0: 95-byte payload, ident 0, hand-computed checksum B861.
        send_meta(16'd95);
        run(95, 94, 1'b0, 1000);
        chk("f0_first_valid_cycle", first_valid, 10);
        for (int i = 0; i < 20; i++)
            chk($sformatf("f0_ip_byte%0d", 14 + i), out_q[14 + i], ip_exp[i]);
        build(95, 16'h0000, 16'hB861, 95);
        cmp_frame("f0", 1'b0);
        chk("f0_tlast_pos", tlast_pos, 128);
        chk("f0_tlast_count", n_tlast, 1);
        chk("f0_err", n_err, 0);

        // Frame 1: DE AD BE EF, ident 1, checksum B8BB.
        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
        send_meta(16'd4);
        run(4, 3, 1'b0, 500);
        build(4, 16'h0001, 16'hB8BB, 4);
        cmp_frame("f1", 1'b0);
        chk("f1_ident_lo", out_q[19], 8'h01);
        chk("f1_last_byte", out_q[37], 8'hEF);
        chk("f1_tlast_pos", tlast_pos, 37);
        chk("f1_err", n_err, 0);

        // Frames 2/3: 64-byte payload without and with random output stalls.
        fill_pattern();
        send_meta(16'd64);
        run(64, 63, 1'b0, 1000);
        build(64, 16'h0002, 16'hB87E, 64);
        cmp_frame("f2_nostall", 1'b0);
        chk("f2_tlast_pos", tlast_pos, 97);
        send_meta(16'd64);
        run(64, 63, 1'b1, 2000);
        build(64, 16'h0003, 16'hB87D, 64);
        cmp_frame("f3_stall", 1'b0);
        chk("f3_first_valid_cycle", first_valid, 10);
        chk("f3_tlast_pos", tlast_pos, 97);
        chk("f3_err", n_err, 0);

        // Frame 4: length 8 but input tlast on the 5th byte.
        send_meta(16'd8);
        run(5, 4, 1'b0, 500);
        build(8, 16'h0004, 16'hB8B4, 5);
        cmp_frame("f4_early", 1'b0);
        chk("f4_tlast_pos", tlast_pos, 38);
        chk("f4_err", n_err, 1);
        chk("f4_s_taken", s_taken, 5);
        chk("f4_meta_ready", meta_ready, 1'b1);
        chk("f4_busy", busy, 1'b0);

        // Frame 5: oversize request is drained without output.
        send_meta(16'd1500);
        run(10, 9, 1'b0, 500);
        chk("f5_no_valid", first_valid, -1);
        chk("f5_out_bytes", out_q.size(), 0);
        chk("f5_err", n_err, 1);
        chk("f5_s_drained", s_taken, 10);

        // Frame 6: normal request after the oversize one.
        send_meta(16'd4);
        run(4, 3, 1'b0, 500);
        build(4, 16'h0000, 16'h0000, 4);
        cmp_frame("f6_after_oversize", 1'b1);
        chk("f6_tlast_pos", tlast_pos, 37);
        chk("f6_err", n_err, 0);

        // Frame 7: reset asserted while header byte 20 is on the output.
        send_meta(16'd8);
        hs = 0; cyc = 0;
        while (hs < 20 && cyc < 100) begin
            @(negedge clk);
            #1 cyc++;
            if (m_tvalid && m_tready) hs++;
        end
        chk("f7_reached_byte20", hs, 20);
        @(negedge clk);
        #1 chk("f7_byte20", m_tdata, 8'h40);
        rst = 1'b1;
        #1;
        chk("f7_rst_tvalid", m_tvalid, 1'b0);
        chk("f7_rst_busy", busy, 1'b0);
        chk("f7_rst_tlast", m_tlast, 1'b0);
        chk("f7_rst_meta_ready", meta_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Frame 8: ident restarts at 0 after reset, checksum B8BC.
        send_meta(16'd4);
        run(4, 3, 1'b0, 500);
        build(4, 16'h0000, 16'hB8BC, 4);
        cmp_frame("f8_post_reset", 1'b0);

        // Frame 9: length 4 reached without input tlast; extra bytes drained.
        send_meta(16'd4);
        run(6, 5, 1'b0, 500);
        build(4, 16'h0001, 16'hB8BB, 4);
        cmp_frame("f9_no_tlast", 1'b0);
        chk("f9_tlast_pos", tlast_pos, 37);
        chk("f9_err", n_err, 1);
        chk("f9_s_taken", s_taken, 6);

        // Frame 10: zero-length payload, tlast on the last header byte.
        send_meta(16'd0);
        run(3, 2, 1'b0, 500);
        build(0, 16'h0002, 16'hB8BE, 0);
        cmp_frame("f10_zero_len", 1'b0);
        chk("f10_tlast_pos", tlast_pos, 33);
        chk("f10_s_taken", s_taken, 0);
        chk("f10_err", n_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
